booth_r4_seq_mult: RTL and testbench
====================================

# booth_r4_seq_mult

Iterative, parametrised radix-4 Booth multiplier with valid/ready handshakes on input and output, and per-operation signed/unsigned selection. It retires one Booth digit per clock and trades the area of the combinational 8x8 Booth-Wallace array for a small sequential datapath. It sits wherever the design needs WIDTH-by-WIDTH products at low area and can tolerate multi-cycle latency.

## Interface
- WIDTH, 8: operand width; must be even and at least 4.
- ITER (localparam), WIDTH/2+1: compute cycles per operation.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- signed_mode  input  1  1 means a and b are two's complement; 0 means unsigned.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  2*WIDTH  a*b, interpreted per the captured mode.
- busy  output  1  high in BUSY or DONE.

## Operation
- **States:**
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1.
- **Transitions:**
  - IDLE to BUSY on in_valid&&in_ready. This edge captures a, b and signed_mode, clears the accumulator and the digit counter.
  - BUSY to DONE on the edge where the digit counter reaches ITER-1.
  - DONE to IDLE on out_valid&&out_ready.
- **Operand extension:** operands are extended to WIDTH+2 bits. Sign extension applies when signed_mode=1, zero extension when signed_mode=0. Multiplier bit -1 is 0.
- **Digit i, for i = 0..ITER-1:**
  - Digit bits are b_ext[2i+1:2i-1], recoded to {0, +1, +2, -1, -2}.
  - The selected multiple of a_ext is shifted left 2i and added to an accumulator of 2*WIDTH+4 bits.
  - Negation is done as invert plus carry-in.
- **Result:** product is the low 2*WIDTH bits of the accumulator. The result is exact for every operand pair in both modes, with no saturation and no overflow.
- **Input during non-IDLE:** in_valid asserted in BUSY or DONE is ignored (in_ready=0). Operands are not re-sampled.
- **Output hold:** product and out_valid hold stable while out_valid && !out_ready.
- **No overlap:** a new operation cannot be accepted in the same cycle as the output handshake. in_ready rises the cycle after DONE exits.

## Timing
- **Reset values:** in_ready=1, out_valid=0, busy=0, product=0, state=IDLE.
- **Reset mid-operation:** an asynchronous reset at any time discards the in-flight operation. No out_valid pulse is produced.
- **Latency:** acceptance edge at t0, BUSY edges at t1..tITER, out_valid high after tITER. Latency is ITER edges (5 for WIDTH=8, 9 for WIDTH=16).
- **Throughput:** one operation per ITER+2 cycles at best, when out_ready is held high.
- **Output transfer:** a transfer occurs on any edge with out_valid && out_ready. out_valid falls on that same edge.
- **Registered outputs:** product and the state are registered. in_ready, out_valid and busy are decoded from the state only, with no combinational path from inputs.

## Structure
- **Package booth_pkg:**
  - state enum {IDLE, BUSY, DONE}.
  - Booth digit enum {ZERO, POS1, POS2, NEG1, NEG2}.
  - function ext_operand(value, signed_mode).
- **Sub-module booth_r4_digit:** purely combinational. It takes 3 multiplier bits and a_ext, and produces the selected, not-yet-shifted multiple plus a negate flag.
- **Top level:** the state machine, digit counter ($clog2(ITER) bits), the shift register for b_ext, and the accumulator.

## Test plan
- **Signed basic:** WIDTH=8, signed 5 * -3. Expect product=16'hFFF1, with out_valid exactly 5 edges after acceptance.
- **Signed corner:** signed -128 * -128 gives 16'h4000. Signed 127 * -128 gives 16'hC080.
- **Mode check:** a=8'hFF, b=8'hFF. Unsigned gives 16'hFE01; signed gives 16'h0001.
- **Backpressure:** hold out_ready=0 for 3 cycles in DONE. product stays stable and in_ready stays 0. A concurrent in_valid with a=3, b=4 is ignored. After the handshake, in_ready=1 next cycle.
- **Reset mid-BUSY:** assert rst during the 2nd BUSY cycle. Expect out_valid=0, in_ready=1 and product=0 immediately. A following signed -12 * -7 returns 16'h0054.
- **Wider instance:** WIDTH=16, signed 32767 * -32768. Expect 32'hC0008000 with latency 9. Then run 1000 random operands in both modes, each checked against a reference multiply.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and the operand-extension helper for the radix-4 Booth multiplier.
package booth_pkg;

    localparam int MAXW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    // Extend a width-bit value (zero-padded into MAXW bits) to MAXW+2 bits,
    // sign-filling above the operand when signed_mode is set.
    function automatic logic [MAXW+1:0] ext_operand(input logic [MAXW-1:0] value,
                                                    input logic signed_mode,
                                                    input int unsigned width);
        logic [MAXW-1:0] msb_sh;
        logic [MAXW+1:0] low_mask;
        logic            fill;
        msb_sh   = value >> (width - 1);
        fill     = signed_mode & msb_sh[0];
        low_mask = ~({(MAXW+2){1'b1}} << width);
        return ({2'b00, value} & low_mask) | ({(MAXW+2){fill}} & ~low_mask);
    endfunction

endpackage

// File: rtl/booth_r4_seq_mult_digit.sv
// Radix-4 Booth recoder: picks 0, a or 2a from three multiplier bits and flags negation.
module booth_r4_digit
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] multiple,
    output logic             negate
);

    digit_t digit;

    // Recode the overlapping bit triplet into a Booth digit.
    always_comb begin
        digit = ZERO;
        case (bits)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

    // Select the unshifted magnitude; the sign is applied later by invert plus carry-in.
    always_comb begin
        multiple = '0;
        negate   = 1'b0;
        case (digit)
            POS1:    multiple = {a_ext[WIDTH+1], a_ext};
            NEG1: begin
                multiple = {a_ext[WIDTH+1], a_ext};
                negate   = 1'b1;
            end
            POS2:    multiple = {a_ext, 1'b0};
            NEG2: begin
                multiple = {a_ext, 1'b0};
                negate   = 1'b1;
            end
            default: multiple = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, valid/ready on both sides.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int CW   = $clog2(ITER);
    localparam int EW   = WIDTH + 2;
    localparam int ACCW = 2 * WIDTH + 4;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [EW-1:0]   a_reg;
    logic [EW:0]     b_sr;     // b_ext with the implicit bit -1 appended at the bottom
    logic [ACCW-1:0] acc;

    logic [EW:0]     multiple;
    logic            negate;
    logic [ACCW-1:0] shifted;
    logic [ACCW-1:0] sum;

    booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
        .bits     (b_sr[2:0]),
        .a_ext    (a_reg),
        .multiple (multiple),
        .negate   (negate)
    );

    // Sign-extend the selected multiple, weight it by 4^cnt and fold it into the accumulator.
    always_comb begin
        shifted = {{(ACCW-EW-1){multiple[EW]}}, multiple} << {cnt, 1'b0};
        sum     = acc + (negate ? ~shifted : shifted) + ACCW'(negate);
    end

    // Handshake FSM, digit counter, multiplier shift register and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            b_sr    <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= EW'(ext_operand(MAXW'(a), signed_mode, WIDTH));
                        b_sr  <= {EW'(ext_operand(MAXW'(b), signed_mode, WIDTH)), 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc  <= sum;
                    b_sr <= b_sr >> 2;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        product <= sum[2*WIDTH-1:0];
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Directed and randomized checks of booth_r4_seq_mult at WIDTH=8 and WIDTH=16.
module tb_booth_r4_seq_mult;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv8 = 1'b0, sm8 = 1'b0, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8, busy8;
    logic [15:0] p8;

    logic        iv16 = 1'b0, sm16 = 1'b0, or16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, busy16;
    logic [31:0] p16;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .signed_mode(sm8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .signed_mode(sm16),
        .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16), .product(p16), .busy(busy16)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Issue one 8-bit operation, check latency and result, then complete the handshake.
    task automatic op8(input string tag, input logic sm, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] exp);
        int lat;
        chk({tag, "_in_ready"}, 64'(ir8), 64'd1);
        sm8 = sm; a8 = aa; b8 = bb; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, 64'(lat), 64'd5);
        chk({tag, "_product"}, 64'(p8), 64'(exp));
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk({tag, "_out_valid_drop"}, 64'(ov8), 64'd0);
    endtask

    task automatic op16(input string tag, input logic sm, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [31:0] exp);
        int lat;
        sm16 = sm; a16 = aa; b16 = bb; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, 64'(lat), 64'd9);
        chk({tag, "_product"}, 64'(p16), 64'(exp));
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        chk({tag, "_in_ready_after"}, 64'(ir16), 64'd1);
    endtask

    initial begin
        int lat;
        int ov_seen;
        logic [15:0] ra, rb;
        logic [31:0] rexp;
        logic        rsm;

        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready8",  64'(ir8),    64'd1);
        chk("rst_out_valid8", 64'(ov8),    64'd0);
        chk("rst_busy8",      64'(busy8),  64'd0);
        chk("rst_product8",   64'(p8),     64'd0);
        chk("rst_in_ready16", 64'(ir16),   64'd1);
        chk("rst_product16",  64'(p16),    64'd0);

        op8("s_5xm3",      1'b1, 8'd5,   8'hFD, 16'hFFF1);
        op8("s_m128xm128", 1'b1, 8'h80,  8'h80, 16'h4000);
        op8("s_127xm128",  1'b1, 8'h7F,  8'h80, 16'hC080);
        op8("u_ffxff",     1'b0, 8'hFF,  8'hFF, 16'hFE01);
        op8("s_ffxff",     1'b1, 8'hFF,  8'hFF, 16'h0001);
        op8("u_0x0",       1'b0, 8'h00,  8'h00, 16'h0000);

        // Backpressure: unsigned 200*100 = 20000, held three cycles with a stray request present.
        sm8 = 1'b0; a8 = 8'd200; b8 = 8'd100; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("bp_latency", 64'(lat), 64'd5);
        sm8 = 1'b1; a8 = 8'd3; b8 = 8'd4; iv8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_product_hold", 64'(p8),   64'h4E20);
            chk("bp_out_valid",    64'(ov8),  64'd1);
            chk("bp_in_ready",     64'(ir8),  64'd0);
            chk("bp_busy",         64'(busy8), 64'd1);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("bp_in_ready_after", 64'(ir8),  64'd1);
        chk("bp_out_valid_after", 64'(ov8), 64'd0);
        chk("bp_product_kept",   64'(p8),  64'h4E20);

        // Reset during the second BUSY cycle.
        sm8 = 1'b1; a8 = 8'd100; b8 = 8'd3; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("mrst_out_valid", 64'(ov8), 64'd0);
        chk("mrst_in_ready",  64'(ir8), 64'd1);
        chk("mrst_product",   64'(p8),  64'd0);
        #3 rst = 1'b0;
        ov_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ov8) ov_seen++;
        end
        chk("mrst_no_out_valid", 64'(ov_seen), 64'd0);
        op8("s_m12xm7", 1'b1, 8'hF4, 8'hF9, 16'h0054);

        op16("w_32767xm32768", 1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
        op16("w_u_ffffxffff",  1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);

        for (int i = 0; i < 1000; i++) begin
            rsm = i[0];
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            if (rsm)
                rexp = 32'($signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb}));
            else
                rexp = {16'h0000, ra} * {16'h0000, rb};
            op16(rsm ? "rnd_s" : "rnd_u", rsm, ra, rb, rexp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
